seg_approx_adder_pipe: RTL

- Parametrised, pipelined successor to the 4-bit selectable-approximation adder.
- Adds two WIDTH-bit operands plus carry-in, with a runtime-selectable number of approximate LSBs (lower-part OR approximation).
- The carry chain is split into SEG-bit segments, one segment per pipeline stage.
- Valid/ready handshakes on both sides; feeds the approximate multiplier's partial-product accumulation tree.

---
 rtl/seg_approx_adder_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seg_approx_adder_pipe.sv
// Pipelined adder with runtime-selectable lower-part-OR approximation.
// The carry chain is cut into SEG-bit segments, one segment per register stage.
module seg_approx_adder_pipe #(
  parameter int WIDTH      = 8,
  parameter int SEG        = 4,
  parameter int APPROX_MAX = 4,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic [SEL_W-1:0] approx_k
);

  localparam int NSEG = WIDTH / SEG;

  function automatic logic [WIDTH-1:0] low_mask(input logic [SEL_W-1:0] k);
    return ~({WIDTH{1'b1}} << k);
  endfunction

  // Replace the low k bits of the rippled result with the OR bits.
  function automatic logic [WIDTH:0] finish_sum(input logic [WIDTH:0]   r,
                                                input logic             cout,
                                                input logic [WIDTH-1:0] orv,
                                                input logic [SEL_W-1:0] k);
    logic [WIDTH-1:0] m;
    m = low_mask(k);
    return {cout, (r[WIDTH-1:0] & ~m) | orv};
  endfunction

  logic             adv;
  logic [SEL_W-1:0] k_in;
  logic [WIDTH-1:0] m_in, a_in, b_in, o_in;
  logic             c_in;

  logic [NSEG-1:0]  vld_d, vld_q;
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] o_d [NSEG];
  logic [WIDTH-1:0] o_q [NSEG];
  logic [SEL_W-1:0] k_d [NSEG];
  logic [SEL_W-1:0] k_q [NSEG];
  logic [WIDTH:0]   r_d [NSEG];
  logic [WIDTH:0]   r_q [NSEG];
  logic             c_d [NSEG];
  logic             c_q [NSEG];
  logic             cin_s [NSEG];
  logic [WIDTH:0]   rin_s [NSEG];
  logic [SEG:0]     seg_sum;
  logic [WIDTH:0]   r_tmp;

  assign adv       = !vld_q[NSEG-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NSEG-1];
  assign sum       = r_q[NSEG-1];
  assign approx_k  = k_q[NSEG-1];

  // Operand conditioning: A' low bits preloaded so the ripple delivers the
  // approximate carry (in1[k-1] & in2[k-1]) into bit k.
  always_comb begin
    k_in = (sel > SEL_W'(APPROX_MAX)) ? SEL_W'(APPROX_MAX) : sel;
    m_in = low_mask(k_in);
    c_in = (k_in == '0) ? cin : |(in1 & in2 & m_in & ~(m_in >> 1));
    a_in = (in1 & ~m_in) | ({WIDTH{c_in}} & m_in);
    b_in = in2 & ~m_in;
    o_in = (in1 | in2) & m_in;
  end

  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = a_in;
    b_d[0]   = b_in;
    o_d[0]   = o_in;
    k_d[0]   = k_in;
    cin_s[0] = c_in;
    rin_s[0] = '0;
    for (int s = 1; s < NSEG; s++) begin
      vld_d[s] = vld_q[s-1];
      a_d[s]   = a_q[s-1];
      b_d[s]   = b_q[s-1];
      o_d[s]   = o_q[s-1];
      k_d[s]   = k_q[s-1];
      cin_s[s] = c_q[s-1];
      rin_s[s] = r_q[s-1];
    end
  end

  always_comb begin
    seg_sum = '0;
    r_tmp   = '0;
    for (int s = 0; s < NSEG; s++) begin
      seg_sum = {1'b0, a_d[s][s*SEG +: SEG]} + {1'b0, b_d[s][s*SEG +: SEG]}
              + {{SEG{1'b0}}, cin_s[s]};
      r_tmp = rin_s[s];
      r_tmp[s*SEG +: SEG] = seg_sum[SEG-1:0];
      if (s == NSEG-1) begin
        r_tmp = finish_sum(r_tmp, seg_sum[SEG], o_d[s], k_d[s]);
      end
      r_d[s] = r_tmp;
      c_d[s] = seg_sum[SEG];
    end
  end

  // Stage registers: the whole pipeline advances or holds as one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < NSEG; s++) begin
        r_q[s] <= '0;
        k_q[s] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      for (int s = 0; s < NSEG; s++) begin
        r_q[s] <= r_d[s];
        k_q[s] <= k_d[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int s = 0; s < NSEG; s++) begin
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
        o_q[s] <= o_d[s];
        c_q[s] <= c_d[s];
      end
    end
  end

endmodule
